// File: rtl/mem_req_arbiter_if.sv
// Upstream inst/data request ports and the shared downstream memory port of mem_req_arbiter.
// The arbiter uses the slave view; whatever drives requests and models memory uses master.
interface mem_req_arbiter_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_wdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic        busy;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        output busy
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        input  busy
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between instruction fetch and data access, one transaction
// at a time; data has fixed priority, bounded by a streak counter so fetch cannot starve.
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    mem_req_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state_reg, state_next;
    logic        owner_reg;          // 1 = data owns the in-flight transaction
    logic [3:0]  streak_reg;
    logic        wr_reg;
    logic [1:0]  size_reg;
    logic [31:0] addr_reg;
    logic [3:0]  wstrb_reg;
    logic [31:0] wdata_reg;

    logic        limit_hit;
    logic        grant_data;
    logic        grant_inst;
    logic        resp_fire;

    // Grants are gated by resetn so no addr_ok is reported for a cycle that reset discards.
    always_comb begin
        limit_hit  = bus.inst_req && (streak_reg == 4'(STARVE_LIMIT));
        grant_data = resetn && (state_reg == IDLE) && bus.data_req && !limit_hit;
        grant_inst = resetn && (state_reg == IDLE) && bus.inst_req && !grant_data;
        resp_fire  = (state_reg == RESP) && bus.mem_data_ok;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg  <= IDLE;
            owner_reg  <= 1'b0;
            streak_reg <= 4'd0;
            wr_reg     <= 1'b0;
            size_reg   <= 2'd0;
            addr_reg   <= 32'd0;
            wstrb_reg  <= 4'd0;
            wdata_reg  <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (grant_data) begin
                owner_reg <= 1'b1;
                wr_reg    <= bus.data_wr;
                size_reg  <= bus.data_size;
                addr_reg  <= bus.data_addr;
                wstrb_reg <= bus.data_wstrb;
                wdata_reg <= bus.data_wdata;
                if (!bus.inst_req) begin
                    streak_reg <= 4'd0;
                end else if (streak_reg != 4'hF) begin
                    streak_reg <= streak_reg + 4'd1;
                end
            end else if (grant_inst) begin
                owner_reg  <= 1'b0;
                wr_reg     <= bus.inst_wr;
                size_reg   <= bus.inst_size;
                addr_reg   <= bus.inst_addr;
                wstrb_reg  <= bus.inst_wstrb;
                wdata_reg  <= bus.inst_wdata;
                streak_reg <= 4'd0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_data || grant_inst) state_next = REQ;
            REQ:     if (bus.mem_addr_ok) state_next = RESP;
            RESP:    if (bus.mem_data_ok) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.inst_addr_ok = grant_inst;
        bus.data_addr_ok = grant_data;
        bus.inst_data_ok = resp_fire && !owner_reg;
        bus.data_data_ok = resp_fire && owner_reg;
        bus.inst_rdata   = ((state_reg == RESP) && !owner_reg) ? bus.mem_rdata : 32'd0;
        bus.data_rdata   = ((state_reg == RESP) && owner_reg)  ? bus.mem_rdata : 32'd0;
        bus.mem_req      = (state_reg == REQ);
        bus.mem_wr       = wr_reg;
        bus.mem_size     = size_reg;
        bus.mem_addr     = addr_reg;
        bus.mem_wstrb    = wstrb_reg;
        bus.mem_wdata    = wdata_reg;
        bus.busy         = (state_reg != IDLE);
    end
endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one SRAM-like memory port between the two CPU requesters: the IF-stage instruction fetch and the EXE/MEM-stage data access. It sits between the pipeline's inst/data request interfaces and the single downstream memory/bridge port. It accepts one transaction at a time, latches its payload, and drives it downstream. It then routes the response back to the requester that issued it. Arbitration is fixed priority (data over inst), with a bounded anti-starvation counter.

## Interface
Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while inst_req is pending before inst is forced to win. Legal range 1..15.

Ports (upstream signals exist twice, with prefixes `inst_` and `data_`; direction and width are identical for both):
- clk  in  1  sole clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- {inst,data}_req  in  1  requester has a valid request.
- {inst,data}_wr  in  1  1 = write, 0 = read.
- {inst,data}_size  in  2  0 = byte, 1 = half, 2 = word; passed through unchanged.
- {inst,data}_addr  in  32  byte address.
- {inst,data}_wstrb  in  4  byte write strobes.
- {inst,data}_wdata  in  32  write data.
- {inst,data}_addr_ok  out  1  request accepted this cycle.
- {inst,data}_data_ok  out  1  response for this requester's accepted request is returned this cycle.
- {inst,data}_rdata  out  32  read data, valid when the matching data_ok is 1.
- mem_req  out  1  downstream request valid.
- mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/2/32/4/32  latched payload.
- mem_addr_ok  in  1  downstream accepted the request.
- mem_data_ok  in  1  downstream response valid.
- mem_rdata  in  32  downstream read data.
- busy  out  1  1 whenever state is not IDLE.

## Operation
- FSM has three states: IDLE, REQ and RESP. Reset state is IDLE.
- **Grant (IDLE only):**
  - data wins if data_req is 1, unless inst_req is 1 and streak == STARVE_LIMIT.
  - Otherwise inst wins if inst_req is 1.
  - The winner's addr_ok is 1 in that same cycle, combinational from state and req.
  - On a grant: latch wr, size, addr, wstrb and wdata into the payload registers, record the grant owner, and go to REQ.
- **Streak counter** (4 bits), updated on each grant:
  - data grant with inst_req = 1: streak increments, saturating at 15.
  - data grant with inst_req = 0: streak clears to 0.
  - inst grant: streak clears to 0.
- **REQ:**
  - mem_req = 1 and mem_* carry the latched payload, held stable.
  - On mem_addr_ok = 1, go to RESP.
- **RESP:**
  - mem_req = 0.
  - On mem_data_ok = 1, the owner's data_ok = 1 and its rdata = mem_rdata, both combinational. Go to IDLE.
  - Write responses also pulse data_ok; rdata is don't-care.
- The non-owner's data_ok is always 0.
- mem_data_ok in IDLE or REQ is ignored (protocol violation; assertion in bench).
- upstream addr_ok is never asserted outside IDLE, so at most one transaction is in flight.
- {inst,data}_rdata drive mem_rdata when owned, else 0.

## Timing
- **Reset** (resetn = 0 at a clock edge):
  - state returns to IDLE and streak, owner and payload clear to 0.
  - all addr_ok, data_ok, rdata, mem_req, mem_* and busy outputs read 0 from the following cycle.
  - Reset in REQ or RESP abandons the transaction: no data_ok is issued. The downstream is reset on the same resetn.
- **Best-case transaction takes 3 cycles:**
  - cycle 0: IDLE, addr_ok.
  - cycle 1: REQ, mem_req with mem_addr_ok.
  - cycle 2: RESP, mem_data_ok and data_ok.
  - cycle 3: IDLE, next grant possible.
- Each cycle of mem_addr_ok = 0 extends REQ by one cycle, and each cycle of mem_data_ok = 0 extends RESP by one cycle.
- A requester may deassert req after its addr_ok, because the payload is already latched.
- A requester whose req is not granted keeps req and payload asserted. The arbiter samples it fresh on each IDLE cycle.
- If both reqs go high in the same IDLE cycle, only one addr_ok is asserted.

## Test plan
- **Single fetch:**
  - Stimulus: inst_req with addr 0x1C000000; mem_addr_ok = 1 immediately; mem_data_ok = 1 in the next cycle with rdata 0x02800404.
  - Required: inst_addr_ok in cycle 0; mem_req with mem_addr = 0x1C000000 in cycle 1; inst_data_ok with inst_rdata = 0x02800404 in cycle 2; data_data_ok stays 0.
- **Simultaneous requests:**
  - Stimulus: inst_req and data_req both raised in an IDLE cycle, data addr 0x100.
  - Required: data_addr_ok first and mem_addr = 0x100 first; inst_addr_ok on the next IDLE cycle (cycle 3).
- **Starvation bound:**
  - Stimulus: data_req and inst_req both held at 1, STARVE_LIMIT = 4.
  - Required: 4 data grants, then an inst grant on the 5th, then data again; streak reads 0 after the inst grant.
- **Write passthrough:**
  - Stimulus: data write to addr 0x8, size 1, wstrb 4'b0011, wdata 0x12345678.
  - Required: the mem_* port shows exactly these values; data_data_ok pulses once; inst outputs stay 0.
- **Backpressure:**
  - Stimulus: mem_addr_ok held at 0 for 3 cycles, then mem_data_ok held at 0 for 2 cycles; a new inst_req arrives meanwhile.
  - Required: mem_req high for 4 cycles with a constant payload; inst_addr_ok stays 0 until the state returns to IDLE; busy = 1 throughout.
- **Reset mid-RESP:**
  - Stimulus: assert resetn = 0 for one cycle while in RESP.
  - Required: the next cycle is IDLE with all outputs 0; no data_ok is ever issued for the abandoned request; a fresh inst_req is then granted normally.
